// File: rtl/button_debounce.sv
// ---------------------------------------------------------------------------
// button_debounce
//
// Conditions four raw push-button pins before the switch/button read stage.
// Each button goes through a 2-FF synchronizer and a per-button stability
// counter.  A new level is accepted only after DEBOUNCE_CYCLES consecutive
// synchronized cycles that differ from the current accepted level.  Any
// return to the accepted level first throws the partial count away.
//
// Parameters:
//   DEBOUNCE_CYCLES : consecutive differing cycles needed to accept (>= 2)
//   CNT_W           : counter width, 2**CNT_W > DEBOUNCE_CYCLES
//   INVERT          : 1 = pins are active-low, inverted before sync
//
// Ports:
//   clk           in   system clock, rising edge
//   rst           in   asynchronous reset, active-high
//   btn_raw[3:0]  in   raw, bouncing, asynchronous button pins
//   button_clr    in   per-button sticky clear (one-cycle pulse)
//   button4       out  debounced level, 1 = pressed
//   button_rise   out  one-cycle pulse on each accepted 0->1 transition
//   button_sticky out  press flag, held until cleared by button_clr
//
// All outputs come straight from flops; btn_raw and button_clr have no
// combinational path to any output.
// ---------------------------------------------------------------------------
module button_debounce #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 20,
  parameter bit INVERT          = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] btn_raw,
  input  logic [3:0] button_clr,
  output logic [3:0] button4,
  output logic [3:0] button_rise,
  output logic [3:0] button_sticky
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [3:0]       b;
  logic [3:0]       sync1;
  logic [3:0]       sync2;
  logic [3:0]       stable;
  logic [CNT_W-1:0] cnt [4];
  logic [3:0]       accept;
  logic [3:0]       set_sticky;

  // Polarity fix-up happens ahead of the synchronizer so everything
  // downstream sees 1 = pressed.
  assign b = INVERT ? ~btn_raw : btn_raw;

  // Accept when the input has differed for the full window; this is the
  // final differing cycle, counted as cnt == DEBOUNCE_CYCLES-1.
  always_comb begin
    accept     = 4'b0000;
    set_sticky = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      accept[i]     = (sync2[i] != stable[i]) && (cnt[i] == CNT_MAX);
      set_sticky[i] = accept[i] && sync2[i];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1         <= 4'b0000;
      sync2         <= 4'b0000;
      stable        <= 4'b0000;
      button_rise   <= 4'b0000;
      button_sticky <= 4'b0000;
      for (int i = 0; i < 4; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      sync1 <= b;
      sync2 <= sync1;
      for (int i = 0; i < 4; i++) begin
        if (sync2[i] == stable[i]) begin
          cnt[i] <= '0;
        end else if (accept[i]) begin
          stable[i] <= sync2[i];
          cnt[i]    <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
      button_rise <= set_sticky;
      // A set on the same edge as a clear wins, so no press is ever lost.
      button_sticky <= set_sticky | (button_sticky & ~button_clr);
    end
  end

  assign button4 = stable;

endmodule

// File: tb/tb_button_debounce.sv
// ---------------------------------------------------------------------------
// tb_button_debounce
//
// Directed bench for button_debounce with DEBOUNCE_CYCLES=4, INVERT=0.
// Inputs change 1 ns after a rising edge; outputs are sampled at that same
// point, i.e. just after the edge that produced them.  "Edge 1" is the first
// rising edge that samples a newly driven raw value; acceptance lands on
// edge 6.
// ---------------------------------------------------------------------------
module tb_button_debounce;

  logic       clk;
  logic       rst;
  logic [3:0] btn_raw;
  logic [3:0] button_clr;
  logic [3:0] button4;
  logic [3:0] button_rise;
  logic [3:0] button_sticky;

  int n_cmp;
  int n_fail;

  button_debounce #(
    .DEBOUNCE_CYCLES(4),
    .CNT_W          (3),
    .INVERT         (1'b0)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .btn_raw      (btn_raw),
    .button_clr   (button_clr),
    .button4      (button4),
    .button_rise  (button_rise),
    .button_sticky(button_sticky)
  );

  // clock/reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // advance n rising edges, landing 1 ns after the last one
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset;
    rst        = 1'b1;
    btn_raw    = 4'b0000;
    button_clr = 4'b0000;
    tick(3);
    n_cmp++;
    if (button4 !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_button4 got=%b exp=%b", button4, 4'b0000);
    end
    n_cmp++;
    if (button_rise !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_rise got=%b exp=%b", button_rise, 4'b0000);
    end
    n_cmp++;
    if (button_sticky !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_sticky got=%b exp=%b", button_sticky, 4'b0000);
    end
    rst = 1'b0;
    tick(2);
  endtask

  task automatic test_clean_press;
    btn_raw = 4'b0001;
    tick(5);
    n_cmp++;
    if (button4 !== 4'b0000 || button_rise !== 4'b0000) begin
      n_fail++;
      $display("FAIL press_edge5 got=%b/%b exp=0000/0000", button4, button_rise);
    end
    tick(1);
    n_cmp++;
    if (button4 !== 4'b0001) begin
      n_fail++;
      $display("FAIL press_level got=%b exp=%b", button4, 4'b0001);
    end
    n_cmp++;
    if (button_rise !== 4'b0001) begin
      n_fail++;
      $display("FAIL press_rise got=%b exp=%b", button_rise, 4'b0001);
    end
    n_cmp++;
    if (button_sticky !== 4'b0001) begin
      n_fail++;
      $display("FAIL press_sticky got=%b exp=%b", button_sticky, 4'b0001);
    end
    tick(1);
    n_cmp++;
    if (button_rise !== 4'b0000 || button4 !== 4'b0001) begin
      n_fail++;
      $display("FAIL press_rise_one_cycle got=%b/%b exp=0000/0001", button_rise, button4);
    end
    tick(3);
    btn_raw = 4'b0000;
    tick(6);
    n_cmp++;
    if (button4 !== 4'b0000 || button_sticky !== 4'b0001) begin
      n_fail++;
      $display("FAIL press_release got=%b/%b exp=0000/0001", button4, button_sticky);
    end
    button_clr = 4'b0001;
    tick(1);
    button_clr = 4'b0000;
    n_cmp++;
    if (button_sticky !== 4'b0000) begin
      n_fail++;
      $display("FAIL press_clear got=%b exp=%b", button_sticky, 4'b0000);
    end
  endtask

  // rst pulse part-way through a count; counting restarts after release
  task automatic test_reset_mid_bounce;
    btn_raw = 4'b0001;
    tick(4);
    #2 rst = 1'b1;
    #2 rst = 1'b0;
    tick(5);
    n_cmp++;
    if (button4 !== 4'b0000) begin
      n_fail++;
      $display("FAIL midreset_edge5 got=%b exp=%b", button4, 4'b0000);
    end
    tick(1);
    n_cmp++;
    if (button4 !== 4'b0001 || button_sticky !== 4'b0001) begin
      n_fail++;
      $display("FAIL midreset_edge6 got=%b/%b exp=0001/0001", button4, button_sticky);
    end
  endtask

  // outputs are nonzero here; rst mid-cycle must clear them before any edge
  task automatic test_async_reset;
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if (button4 !== 4'b0000) begin
      n_fail++;
      $display("FAIL async_button4 got=%b exp=%b", button4, 4'b0000);
    end
    n_cmp++;
    if (button_sticky !== 4'b0000 || button_rise !== 4'b0000) begin
      n_fail++;
      $display("FAIL async_flags got=%b/%b exp=0000/0000", button_sticky, button_rise);
    end
    btn_raw = 4'b0000;
    tick(2);
    rst = 1'b0;
    tick(1);
  endtask

  task automatic test_bounce;
    logic [3:0] pat [4];
    pat[0] = 4'b0010;
    pat[1] = 4'b0000;
    pat[2] = 4'b0010;
    pat[3] = 4'b0000;
    for (int k = 0; k < 8; k++) begin
      btn_raw = pat[k/2];
      tick(1);
      n_cmp++;
      if ({button4[1], button_rise[1], button_sticky[1]} !== 3'b000) begin
        n_fail++;
        $display("FAIL bounce_cycle%0d got=%b exp=000", k,
                 {button4[1], button_rise[1], button_sticky[1]});
      end
    end
    for (int k = 0; k < 8; k++) begin
      tick(1);
      n_cmp++;
      if ({button4[1], button_rise[1], button_sticky[1]} !== 3'b000) begin
        n_fail++;
        $display("FAIL bounce_rest%0d got=%b exp=000", k,
                 {button4[1], button_rise[1], button_sticky[1]});
      end
    end
  endtask

  task automatic test_bounce_settle;
    btn_raw = 4'b0100;
    tick(1);
    btn_raw = 4'b0000;
    tick(1);
    btn_raw = 4'b0100;
    tick(5);
    n_cmp++;
    if (button4 !== 4'b0000 || button_rise !== 4'b0000) begin
      n_fail++;
      $display("FAIL settle_edge5 got=%b/%b exp=0000/0000", button4, button_rise);
    end
    tick(1);
    n_cmp++;
    if (button4 !== 4'b0100 || button_rise !== 4'b0100) begin
      n_fail++;
      $display("FAIL settle_edge6 got=%b/%b exp=0100/0100", button4, button_rise);
    end
    tick(1);
    n_cmp++;
    if (button_rise !== 4'b0000) begin
      n_fail++;
      $display("FAIL settle_single_pulse got=%b exp=%b", button_rise, 4'b0000);
    end
    btn_raw = 4'b0000;
    tick(6);
    button_clr = 4'b0100;
    tick(1);
    button_clr = 4'b0000;
    n_cmp++;
    if (button4 !== 4'b0000 || button_sticky !== 4'b0000) begin
      n_fail++;
      $display("FAIL settle_cleanup got=%b/%b exp=0000/0000", button4, button_sticky);
    end
  endtask

  task automatic test_release_sticky;
    btn_raw = 4'b1000;
    tick(8);
    n_cmp++;
    if (button4 !== 4'b1000 || button_sticky !== 4'b1000) begin
      n_fail++;
      $display("FAIL rel_pressed got=%b/%b exp=1000/1000", button4, button_sticky);
    end
    btn_raw = 4'b0000;
    for (int k = 1; k <= 6; k++) begin
      tick(1);
      n_cmp++;
      if (button_rise !== 4'b0000) begin
        n_fail++;
        $display("FAIL rel_no_rise edge%0d got=%b exp=0000", k, button_rise);
      end
      if (k == 5) begin
        n_cmp++;
        if (button4 !== 4'b1000) begin
          n_fail++;
          $display("FAIL rel_edge5 got=%b exp=%b", button4, 4'b1000);
        end
      end
    end
    n_cmp++;
    if (button4 !== 4'b0000 || button_sticky !== 4'b1000) begin
      n_fail++;
      $display("FAIL rel_edge6 got=%b/%b exp=0000/1000", button4, button_sticky);
    end
    tick(2);
    button_clr = 4'b1000;
    tick(1);
    button_clr = 4'b0000;
    n_cmp++;
    if (button_sticky !== 4'b0000) begin
      n_fail++;
      $display("FAIL rel_clear got=%b exp=%b", button_sticky, 4'b0000);
    end
  endtask

  task automatic test_simultaneous;
    btn_raw = 4'b0101;
    tick(5);
    button_clr = 4'b0101;   // lands on the accept edge
    tick(1);
    button_clr = 4'b0000;
    n_cmp++;
    if (button_rise !== 4'b0101) begin
      n_fail++;
      $display("FAIL simul_rise got=%b exp=%b", button_rise, 4'b0101);
    end
    n_cmp++;
    if (button_sticky !== 4'b0101 || button4 !== 4'b0101) begin
      n_fail++;
      $display("FAIL simul_set_wins got=%b/%b exp=0101/0101", button_sticky, button4);
    end
    tick(1);
    n_cmp++;
    if (button_rise !== 4'b0000 || button_sticky !== 4'b0101) begin
      n_fail++;
      $display("FAIL simul_after got=%b/%b exp=0000/0101", button_rise, button_sticky);
    end
    button_clr = 4'b0101;
    tick(1);
    button_clr = 4'b0000;
    n_cmp++;
    if (button_sticky !== 4'b0000) begin
      n_fail++;
      $display("FAIL simul_clear got=%b exp=%b", button_sticky, 4'b0000);
    end
    // still held: no re-set of the flag without a new 0->1 accept
    tick(3);
    n_cmp++;
    if (button_sticky !== 4'b0000 || button4 !== 4'b0101) begin
      n_fail++;
      $display("FAIL simul_hold_no_reset got=%b/%b exp=0000/0101", button_sticky, button4);
    end
  endtask

  initial begin
    n_cmp      = 0;
    n_fail     = 0;
    rst        = 1'b1;
    btn_raw    = 4'b0000;
    button_clr = 4'b0000;
    test_reset;
    test_clean_press;
    test_reset_mid_bounce;
    test_async_reset;
    test_bounce;
    test_bounce_settle;
    test_release_sticky;
    test_simultaneous;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
